// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: decoder opcodes, field
// positions and the program-loader state encoding.
package cpu_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_IMM   = 6'b111111;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int FUNCT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } ld_state_e;

  function automatic logic opc_ok(input logic [5:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_IMM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master = stream source / memory, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/word_packer.sv
// Packs stream bytes little-endian into a 32-bit word.
// word_full flags the transfer that supplies byte 3.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  data,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0] cnt;

  assign word_full = load && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      word <= 32'd0;
    end else if (clr) begin
      cnt  <= 2'd0;
      word <= 32'd0;
    end else if (load) begin
      word[{cnt, 3'b000} +: 8] <= data;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length byte, then N words checked and
// written to imem; core held in reset until done.
module imem_loader
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_hold,
  output logic         done,
  output logic         err
);

  localparam int IW  = ADDR_W + 1;
  localparam int CAP = 1 << ADDR_W;

  ld_state_e   state, state_nx;
  logic [IW-1:0] idx, num, idx_inc;
  logic        take, restart, clr;
  logic        word_full;
  logic [31:0] word;
  logic [5:0]  opc;

  assign take    = bus.in_valid && bus.in_ready;
  assign restart = start && (state == S_IDLE ||
                   state == S_DONE || state == S_ERROR);
  assign clr     = restart || (state == S_WRITE);
  assign idx_inc = idx + IW'(1);
  // opcode of the word being completed lives in the last byte
  assign opc = bus.in_data[OPC_MSB-24:OPC_LSB-24];

  word_packer u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (take && state == S_DATA),
    .data      (bus.in_data),
    .word_full (word_full),
    .word      (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      num   <= '0;
    end else begin
      state <= state_nx;
      if (restart)
        idx <= '0;
      else if (state == S_WRITE)
        idx <= idx_inc;
      if (state == S_LEN && take)
        num <= IW'(bus.in_data);
    end
  end

  always_comb begin
    state_nx       = state;
    bus.in_ready   = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = idx[ADDR_W-1:0];
    bus.imem_wdata = word;
    core_hold      = 1'b1;
    done           = 1'b0;
    err            = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_LEN;
      end
      S_LEN: begin
        bus.in_ready = 1'b1;
        if (take) begin
          if (bus.in_data == 8'd0)
            state_nx = S_DONE;
          else if (32'(bus.in_data) > 32'(CAP))
            state_nx = S_ERROR;
          else
            state_nx = S_DATA;
        end
      end
      S_DATA: begin
        bus.in_ready = 1'b1;
        if (word_full)
          state_nx = opc_ok(opc) ? S_WRITE : S_ERROR;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        state_nx = (idx_inc == num) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) state_nx = S_LEN;
      end
      S_ERROR: begin
        err = 1'b1;
        if (start) state_nx = S_LEN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are
// queued by stimulus, popped by a write monitor.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_hold, done, err;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  in_session = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic wr_t mk(input int a, input logic [31:0] d);
    wr_t r;
    r.addr = ADDR_W'(a);
    r.data = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (bus.imem_we) begin
        chk("ready_low_on_write", 32'(bus.in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
          chk("wr_data", bus.imem_wdata, e.data);
        end
      end else if (in_session) begin
        chk("ready_in_session", 32'(bus.in_ready), 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit last);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1 (byte %0h)", b);
    end
    if (last) in_session = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps,
                           input bit last);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0,
                last && i == 3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_session = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // legal two-word load
    exp_q.push_back(mk(0, 32'h0000_0000));
    exp_q.push_back(mk(1, 32'hFC00_0005));
    pulse_start();
    send_byte(8'd2, 0, 1'b0);
    send_word(32'h0000_0000, 1'b0, 1'b0);
    send_word(32'hFC00_0005, 1'b0, 1'b1);
    chk("latency_we", 32'(bus.imem_we), 32'd1);
    chk("latency_addr", 32'(bus.imem_addr), 32'd1);
    @(negedge clk);
    chk("legal_done", 32'(done), 32'd1);
    chk("legal_hold", 32'(core_hold), 32'd0);
    chk("legal_err", 32'(err), 32'd0);
    chk("legal_q_empty", 32'(exp_q.size()), 32'd0);

    // illegal opcode, restarted from DONE
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_hold", 32'(core_hold), 32'd1);
    send_byte(8'd1, 0, 1'b0);
    send_word(32'h0800_0000, 1'b0, 1'b1);
    chk("opc_err", 32'(err), 32'd1);
    chk("opc_hold", 32'(core_hold), 32'd1);
    chk("opc_ready", 32'(bus.in_ready), 32'd0);
    chk("opc_we", 32'(bus.imem_we), 32'd0);
    @(negedge clk);
    chk("opc_err_sticky", 32'(err), 32'd1);

    // N=0, restarted from ERROR
    pulse_start();
    chk("restart_err_clr", 32'(err), 32'd0);
    send_byte(8'd0, 0, 1'b1);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_hold", 32'(core_hold), 32'd0);
    chk("n0_we", 32'(bus.imem_we), 32'd0);

    // N=65 exceeds capacity
    pulse_start();
    send_byte(8'd65, 0, 1'b1);
    chk("n65_err", 32'(err), 32'd1);
    chk("n65_hold", 32'(core_hold), 32'd1);

    // N=64 fills memory exactly
    pulse_start();
    send_byte(8'd64, 0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      w = (i % 2 == 1) ? (32'hFC00_0000 | 32'(i)) : 32'(i);
      exp_q.push_back(mk(i, w));
      send_word(w, 1'b0, i == 63);
    end
    @(negedge clk);
    chk("n64_done", 32'(done), 32'd1);
    chk("n64_err", 32'(err), 32'd0);
    chk("n64_q_empty", 32'(exp_q.size()), 32'd0);

    // legal load again with random valid gaps
    exp_q.push_back(mk(0, 32'h0000_0000));
    exp_q.push_back(mk(1, 32'hFC00_0005));
    pulse_start();
    send_byte(8'd2, 2, 1'b0);
    send_word(32'h0000_0000, 1'b1, 1'b0);
    send_word(32'hFC00_0005, 1'b1, 1'b1);
    @(negedge clk);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_q_empty", 32'(exp_q.size()), 32'd0);

    // start inside DATA has no effect
    exp_q.push_back(mk(0, 32'hFC00_00AB));
    pulse_start();
    send_byte(8'd1, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFC, 0, 1'b1);
    @(negedge clk);
    chk("ign_start_done", 32'(done), 32'd1);
    chk("ign_start_err", 32'(err), 32'd0);
    chk("ign_start_q_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of word 1
    exp_q.push_back(mk(0, 32'hFC00_0011));
    pulse_start();
    send_byte(8'd2, 0, 1'b0);
    send_word(32'hFC00_0011, 1'b0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    in_session = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("mid_rst_wdata", bus.imem_wdata, 32'd0);
    chk("mid_rst_hold", 32'(core_hold), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q.push_back(mk(0, 32'h0000_0044));
    pulse_start();
    send_byte(8'd1, 0, 1'b0);
    send_word(32'h0000_0044, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_hold", 32'(core_hold), 32'd0);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
